character_renderer: RTL

CHARACTER_RENDERER -- requirements
Module: character_renderer

---
 rtl/character_renderer_if.sv | 26 ++
 rtl/character_renderer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/character_renderer_if.sv
// Renderer bus: sprite position inputs, sprite ROM port and video outputs.
interface character_renderer_if #(
  parameter int PHY_WIDTH   = 10,
  parameter int PIXEL_WIDTH = 12
);
  logic signed [PHY_WIDTH:0] char_pos_x;
  logic signed [PHY_WIDTH:0] char_pos_y;
  logic [1:0]                char_face;
  logic [9:0]                sprite_addr;
  logic [PIXEL_WIDTH-1:0]    sprite_data;
  logic                      hsync;
  logic                      vsync;
  logic                      de;
  logic [PIXEL_WIDTH-1:0]    rgb;
  logic                      frame_start;

  modport master (
    input  char_pos_x, char_pos_y, char_face, sprite_data,
    output sprite_addr, hsync, vsync, de, rgb, frame_start
  );

  modport slave (
    output char_pos_x, char_pos_y, char_face, sprite_data,
    input  sprite_addr, hsync, vsync, de, rgb, frame_start
  );
endinterface

// File: rtl/character_renderer.sv
// VGA-timed renderer drawing a ROM sprite over a walled map rectangle.
// Sprite position/facing is sampled once per frame at the start of vsync.
module character_renderer #(
  parameter int PHY_WIDTH    = 10,
  parameter int PIXEL_WIDTH  = 12,
  parameter int WALL_WIDTH   = 10,
  parameter int MAP_WIDTH_X  = 100,
  parameter int MAP_WIDTH_Y  = 100,
  parameter int MAP_X_OFFSET = 270,
  parameter int MAP_Y_OFFSET = 50,
  parameter int CHAR_WIDTH_X = 32,
  parameter int CHAR_WIDTH_Y = 32,
  parameter logic [PIXEL_WIDTH-1:0] WALL_COLOR = 12'h888,
  parameter logic [PIXEL_WIDTH-1:0] BG_COLOR   = 12'h000,
  parameter logic [PIXEL_WIDTH-1:0] KEY_COLOR  = 12'hF0F,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  character_renderer_if.master  bus
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned CW     = PHY_WIDTH + 2;
  localparam int unsigned ADDR_W = 10;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic signed [CW-1:0] Y_TOP  = CW'(V_VISIBLE - 1);
  localparam logic signed [CW-1:0] CHX    = CW'(CHAR_WIDTH_X);
  localparam logic signed [CW-1:0] CHY    = CW'(CHAR_WIDTH_Y);
  localparam logic signed [CW-1:0] CHX_M1 = CW'(CHAR_WIDTH_X - 1);
  localparam logic signed [CW-1:0] CHY_M1 = CW'(CHAR_WIDTH_Y - 1);
  localparam logic signed [CW-1:0] MX0    = CW'(MAP_X_OFFSET);
  localparam logic signed [CW-1:0] MX1    = CW'(MAP_X_OFFSET + MAP_WIDTH_X);
  localparam logic signed [CW-1:0] MY0    = CW'(MAP_Y_OFFSET);
  localparam logic signed [CW-1:0] MY1    = CW'(MAP_Y_OFFSET + MAP_WIDTH_Y);
  localparam logic signed [CW-1:0] MXW0   = CW'(MAP_X_OFFSET + WALL_WIDTH);
  localparam logic signed [CW-1:0] MXW1   = CW'(MAP_X_OFFSET + MAP_WIDTH_X - WALL_WIDTH);
  localparam logic signed [CW-1:0] MYW0   = CW'(MAP_Y_OFFSET + WALL_WIDTH);
  localparam logic signed [CW-1:0] MYW1   = CW'(MAP_Y_OFFSET + MAP_WIDTH_Y - WALL_WIDTH);

  logic [1:0]                div;
  logic                      pix_tick;
  logic [CNT_W-1:0]          hcnt, vcnt;
  logic signed [PHY_WIDTH:0] sh_x, sh_y;
  logic [1:0]                sh_face;
  logic                      frame_start_r;

  logic signed [CW-1:0] wx, wy, px, py, dx, dy, col, row, addr_full;
  logic                 sprite_hit, in_map, wall_hit, de_c, hs_c, vs_c;
  logic [ADDR_W-1:0]    addr_c;

  logic [ADDR_W-1:0]      addr_r;
  logic                   s1_sprite, s1_wall, s1_de, s1_hs, s1_vs;
  logic [PIXEL_WIDTH-1:0] rgb_r;
  logic                   de_r, hs_r, vs_r;

  assign pix_tick = (div == 2'd3);

  // Pixel divider, raster counters and once-per-frame position shadow
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div           <= '0;
      hcnt          <= '0;
      vcnt          <= '0;
      sh_x          <= '0;
      sh_y          <= '0;
      sh_face       <= 2'b01;
      frame_start_r <= 1'b0;
    end else begin
      div           <= div + 2'd1;
      frame_start_r <= 1'b0;
      if (pix_tick) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
        end else begin
          hcnt <= hcnt + CNT_W'(1);
        end
        if (hcnt == '0 && vcnt == VS_BEG) begin
          sh_x          <= bus.char_pos_x;
          sh_y          <= bus.char_pos_y;
          sh_face       <= bus.char_face;
          frame_start_r <= 1'b1;
        end
      end
    end
  end

  // Screen-to-world mapping, sprite/wall hit tests and ROM address
  always_comb begin
    wx = CW'(hcnt);
    wy = Y_TOP - CW'(vcnt);
    px = CW'(sh_x);
    py = CW'(sh_y);
    dx = wx - px;
    dy = wy - py;
    sprite_hit = !dx[CW-1] && (dx < CHX) && !dy[CW-1] && (dy < CHY);
    col = (sh_face == 2'b11) ? CHX_M1 - dx : dx;
    row = CHY_M1 - dy;
    addr_full = row * CHX + col;
    addr_c = sprite_hit ? ADDR_W'(addr_full) : '0;
    in_map = (wx >= MX0) && (wx < MX1) && (wy >= MY0) && (wy < MY1);
    wall_hit = in_map && ((wx < MXW0) || (wx >= MXW1) || (wy < MYW0) || (wy >= MYW1));
    de_c = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    hs_c = !((hcnt >= HS_BEG) && (hcnt < HS_END));
    vs_c = !((vcnt >= VS_BEG) && (vcnt < VS_END));
  end

  // Stage 1 issues the ROM read; stage 2 resolves colour once data returns
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_r    <= '0;
      s1_sprite <= 1'b0;
      s1_wall   <= 1'b0;
      s1_de     <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      rgb_r     <= '0;
      de_r      <= 1'b0;
      hs_r      <= 1'b1;
      vs_r      <= 1'b1;
    end else begin
      addr_r    <= addr_c;
      s1_sprite <= sprite_hit;
      s1_wall   <= wall_hit;
      s1_de     <= de_c;
      s1_hs     <= hs_c;
      s1_vs     <= vs_c;
      if (!s1_de)
        rgb_r <= '0;
      else if (s1_sprite && (bus.sprite_data != KEY_COLOR))
        rgb_r <= bus.sprite_data;
      else if (s1_wall)
        rgb_r <= WALL_COLOR;
      else
        rgb_r <= BG_COLOR;
      de_r <= s1_de;
      hs_r <= s1_hs;
      vs_r <= s1_vs;
    end
  end

  assign bus.sprite_addr = addr_r;
  assign bus.rgb         = rgb_r;
  assign bus.de          = de_r;
  assign bus.hsync       = hs_r;
  assign bus.vsync       = vs_r;
  assign bus.frame_start = frame_start_r;

endmodule
